// File: rtl/punc_debug_pkg.sv
// rtl/punc_debug_pkg.sv - shared types and tag constants for the PUnC debug dumper
// Ports: none (package only).
package punc_debug_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_SEND    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PH_PC  = 2'd0,
    PH_RF  = 2'd1,
    PH_MEM = 2'd2
  } phase_e;

  localparam logic [1:0] TAG_PC  = 2'd0;
  localparam logic [1:0] TAG_RF  = 2'd1;
  localparam logic [1:0] TAG_MEM = 2'd2;

endpackage

// File: rtl/punc_debug_out_reg.sv
// rtl/punc_debug_out_reg.sv - single-entry valid/ready output holding register
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load_i              capture data_i/tag_i/last_i and raise valid_o
//   data_i, tag_i, last_i  word to present
//   ready_i             sink ready; valid_o drops the cycle after valid_o && ready_i
//   valid_o, data_o, tag_o, last_o  registered stream word, stable while stalled
module punc_debug_out_reg #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              last_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [TAG_W-1:0]  tag_q;
  logic              last_q;

  // Payload only changes on load, so it holds stable for the whole stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      tag_q   <= tag_i;
      last_q  <= last_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign tag_o   = tag_q;
  assign last_o  = last_q;

endmodule

// File: rtl/punc_debug_dumper.sv
// rtl/punc_debug_dumper.sv - streams a tagged PC / register / memory snapshot of the PUnC core
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start, mem_base, mem_len  dump request and memory window (captured in IDLE)
//   busy                      dump in progress
//   mem_debug_addr, rf_debug_addr                 debug addresses to the core
//   mem_debug_data, rf_debug_data, pc_debug_data  debug data from the core
//   out_valid, out_ready, out_data, out_tag, out_last  output word stream
module punc_debug_dumper
  import punc_debug_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_REGS  = 8,
  parameter int RF_ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_W-1:0]    mem_base,
  input  logic [DATA_W-1:0]    mem_len,
  output logic                 busy,
  output logic [DATA_W-1:0]    mem_debug_addr,
  output logic [RF_ADDR_W-1:0] rf_debug_addr,
  input  logic [DATA_W-1:0]    mem_debug_data,
  input  logic [DATA_W-1:0]    rf_debug_data,
  input  logic [DATA_W-1:0]    pc_debug_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [1:0]           out_tag,
  output logic                 out_last
);

  localparam logic [RF_ADDR_W-1:0] LAST_REG = RF_ADDR_W'(NUM_REGS - 1);

  state_e               state_q;
  phase_e               phase_q;
  logic [RF_ADDR_W-1:0] reg_idx_q;
  logic [DATA_W-1:0]    addr_q;
  logic [DATA_W-1:0]    remain_q;
  logic                 busy_q;
  logic [DATA_W-1:0]    mem_addr_q;
  logic [RF_ADDR_W-1:0] rf_addr_q;

  logic [DATA_W-1:0]    cap_data_d;
  logic [1:0]           cap_tag_d;
  logic                 cap_last_d;
  logic                 load;
  logic                 fire;

  // Word selected for the current phase; registered by the output stage in CAPTURE.
  always_comb begin
    cap_data_d = pc_debug_data;
    cap_tag_d  = TAG_PC;
    cap_last_d = 1'b0;
    case (phase_q)
      PH_RF: begin
        cap_data_d = rf_debug_data;
        cap_tag_d  = TAG_RF;
        // Last register closes the dump only when no memory window follows.
        cap_last_d = (reg_idx_q == LAST_REG) && (remain_q == '0);
      end
      PH_MEM: begin
        cap_data_d = mem_debug_data;
        cap_tag_d  = TAG_MEM;
        cap_last_d = (remain_q == DATA_W'(1));
      end
      default: ;
    endcase
  end

  assign load = (state_q == ST_CAPTURE);
  assign fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_PC;
      reg_idx_q  <= '0;
      addr_q     <= '0;
      remain_q   <= '0;
      busy_q     <= 1'b0;
      mem_addr_q <= '0;
      rf_addr_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q    <= mem_base;
            remain_q  <= mem_len;
            phase_q   <= PH_PC;
            reg_idx_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // Address becomes visible for the whole CAPTURE cycle before sampling.
          case (phase_q)
            PH_RF:   rf_addr_q  <= reg_idx_q;
            PH_MEM:  mem_addr_q <= addr_q;
            default: ;
          endcase
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state_q <= ST_SEND;
        end
        ST_SEND: begin
          if (fire) begin
            state_q <= ST_SETUP;
            case (phase_q)
              PH_PC: begin
                phase_q   <= PH_RF;
                reg_idx_q <= '0;
              end
              PH_RF: begin
                if (reg_idx_q != LAST_REG) begin
                  reg_idx_q <= reg_idx_q + 1'b1;
                end else if (remain_q != '0) begin
                  phase_q <= PH_MEM;
                end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
                end
              end
              PH_MEM: begin
                addr_q   <= addr_q + 1'b1;
                remain_q <= remain_q - 1'b1;
                if (remain_q == DATA_W'(1)) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
                end
              end
              default: begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            endcase
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  punc_debug_out_reg #(
    .DATA_W(DATA_W),
    .TAG_W (2)
  ) u_out_reg (
    .clk    (clk),
    .rst_n  (rst),
    .load_i (load),
    .data_i (cap_data_d),
    .tag_i  (cap_tag_d),
    .last_i (cap_last_d),
    .ready_i(out_ready),
    .valid_o(out_valid),
    .data_o (out_data),
    .tag_o  (out_tag),
    .last_o (out_last)
  );

  assign busy           = busy_q;
  assign mem_debug_addr = mem_addr_q;
  assign rf_debug_addr  = rf_addr_q;

endmodule

// File: tb/tb_punc_debug_dumper.sv
// tb/tb_punc_debug_dumper.sv - scoreboard testbench for punc_debug_dumper
module tb_punc_debug_dumper;
  import punc_debug_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] mem_base = 16'h0;
  logic [15:0] mem_len = 16'h0;
  logic        busy;
  logic [15:0] mem_debug_addr;
  logic [2:0]  rf_debug_addr;
  logic [15:0] mem_debug_data;
  logic [15:0] rf_debug_data;
  logic [15:0] pc_debug_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [1:0]  out_tag;
  logic        out_last;

  // Core debug model
  logic [15:0] pc_reg;
  logic [15:0] rf_arr [0:7];
  logic [15:0] mem_arr [0:65535];
  assign mem_debug_data = mem_arr[mem_debug_addr];
  assign rf_debug_data  = rf_arr[rf_debug_addr];
  assign pc_debug_data  = pc_reg;

  punc_debug_dumper dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mem_base      (mem_base),
    .mem_len       (mem_len),
    .busy          (busy),
    .mem_debug_addr(mem_debug_addr),
    .rf_debug_addr (rf_debug_addr),
    .mem_debug_data(mem_debug_data),
    .rf_debug_data (rf_debug_data),
    .pc_debug_data (pc_debug_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_tag       (out_tag),
    .out_last      (out_last)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  tag;
    logic        last;
  } word_t;

  word_t       exp_q[$];
  logic [15:0] addr_log[$];
  logic [15:0] prev_addr = 16'h0;
  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  int hold_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake, checks stall stability.
  word_t mon_w;
  word_t held_w;
  logic  held_v = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid) begin
        chk("stall_data", 32'(out_data), 32'(held_w.data));
        chk("stall_tag", 32'(out_tag), 32'(held_w.tag));
        chk("stall_last", 32'(out_last), 32'(held_w.last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          mon_w = exp_q.pop_front();
          chk("word_data", 32'(out_data), 32'(mon_w.data));
          chk("word_tag", 32'(out_tag), 32'(mon_w.tag));
          chk("word_last", 32'(out_last), 32'(mon_w.last));
        end
      end
      held_v = out_valid && !out_ready;
      held_w = '{data: out_data, tag: out_tag, last: out_last};
    end
    if (mem_debug_addr != prev_addr) begin
      addr_log.push_back(mem_debug_addr);
      prev_addr = mem_debug_addr;
    end
  end

  // Sink ready driver: 0 = always ready, 1 = random with a 5-cycle stall on R3,
  // 3 = ready until the first MEM word, otherwise never ready.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin
        if (out_valid && out_tag == TAG_RF && out_data == 16'h1113 && hold_cnt < 5) begin
          out_ready = 1'b0;
          hold_cnt++;
        end else if (out_valid && out_tag == TAG_RF && out_data == 16'h1113) begin
          out_ready = 1'b1;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      3: out_ready = !(out_valid && out_tag == TAG_MEM);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic push_dump(input logic [15:0] base, input logic [15:0] len);
    word_t w;
    logic [15:0] a;
    w = '{data: pc_reg, tag: TAG_PC, last: 1'b0};
    exp_q.push_back(w);
    for (int i = 0; i < 8; i++) begin
      w = '{data: rf_arr[i], tag: TAG_RF, last: (i == 7 && len == 16'h0)};
      exp_q.push_back(w);
    end
    for (int i = 0; i < int'(len); i++) begin
      a = base + 16'(i);
      w = '{data: mem_arr[a], tag: TAG_MEM, last: (i == int'(len) - 1)};
      exp_q.push_back(w);
    end
  endtask

  // Returns just after the start edge; window inputs are then scrambled.
  task automatic do_start(input logic [15:0] base, input logic [15:0] len);
    @(posedge clk);
    #1;
    start    = 1'b1;
    mem_base = base;
    mem_len  = len;
    @(posedge clk);
    #1;
    start    = 1'b0;
    mem_base = 16'h5555;
    mem_len  = 16'h0007;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk({name, "_busy_clear"}, 32'(busy), 32'h0);
    chk({name, "_all_words"}, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, 32'(busy), 32'h0);
    chk({name, "_valid"}, 32'(out_valid), 32'h0);
    chk({name, "_last"}, 32'(out_last), 32'h0);
    chk({name, "_data"}, 32'(out_data), 32'h0);
    chk({name, "_tag"}, 32'(out_tag), 32'h0);
    chk({name, "_mem_addr"}, 32'(mem_debug_addr), 32'h0);
    chk({name, "_rf_addr"}, 32'(rf_debug_addr), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int got;
    logic [15:0] exp_addr [4];
    exp_addr[0] = 16'hFFFE;
    exp_addr[1] = 16'hFFFF;
    exp_addr[2] = 16'h0000;
    exp_addr[3] = 16'h0001;

    pc_reg = 16'h3000;
    for (int i = 0; i < 8; i++) rf_arr[i] = 16'h1110 + 16'(i);
    mem_arr[16'h3000] = 16'hAAAA;
    mem_arr[16'h3001] = 16'hBBBB;
    mem_arr[16'h3002] = 16'hCCCC;
    mem_arr[16'hFFFE] = 16'hDE01;
    mem_arr[16'hFFFF] = 16'hDE02;
    mem_arr[16'h0000] = 16'hDE03;
    mem_arr[16'h0001] = 16'hDE04;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;

    // Test 1: 3-word window, always ready, 36-cycle dump
    rdy_mode = 0;
    push_dump(16'h3000, 16'd3);
    do_start(16'h3000, 16'd3);
    chk("t1_busy_after_start", 32'(busy), 32'h1);
    cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        cyc = c;
        break;
      end
    end
    chk("t1_cycles", 32'(cyc), 32'd36);
    chk("t1_all_words", 32'(exp_q.size()), 32'h0);

    // Test 2: empty window, last on R7, memory address untouched
    addr_log.delete();
    push_dump(16'h3000, 16'd0);
    do_start(16'h3000, 16'd0);
    wait_idle(100, "t2");
    chk("t2_addr_changes", 32'(addr_log.size()), 32'h0);

    // Test 3: window wrapping through 0xFFFF
    addr_log.delete();
    push_dump(16'hFFFE, 16'd4);
    do_start(16'hFFFE, 16'd4);
    wait_idle(100, "t3");
    chk("t3_addr_count", 32'(addr_log.size()), 32'd4);
    if (addr_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t3_addr_seq", 32'(addr_log[i]), 32'(exp_addr[i]));
    end

    // Test 4: random back-pressure with a 5-cycle stall on R3
    hold_cnt = 0;
    rdy_mode = 1;
    push_dump(16'h3000, 16'd3);
    do_start(16'h3000, 16'd3);
    wait_idle(400, "t4");
    chk("t4_r3_stall_cycles", 32'(hold_cnt), 32'd5);
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Test 5: start mid-dump and on the final handshake are ignored
    push_dump(16'h3000, 16'd2);
    do_start(16'h3000, 16'd2);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      start   = (c == 10 || c == 32);
      mem_len = 16'd5;
      if (c == 33) chk("t5_busy_final", 32'(busy), 32'h0);
    end
    start = 1'b0;
    chk("t5_not_restarted", 32'(busy), 32'h0);
    chk("t5_all_words", 32'(exp_q.size()), 32'h0);

    // Test 6: asynchronous reset during the MEM phase
    rdy_mode = 3;
    push_dump(16'h3000, 16'd3);
    do_start(16'h3000, 16'd3);
    got = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid && out_tag == TAG_MEM) begin
        got = 1;
        break;
      end
    end
    chk("t6_reached_mem", 32'(got), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("t6_async_reset");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    rdy_mode = 0;

    // Test 7: full dump after the aborted one
    push_dump(16'h3000, 16'd3);
    do_start(16'h3000, 16'd3);
    wait_idle(100, "t7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/punc_debug_dumper.md
Name: punc_debug_dumper

Overview:
- Host-side counterpart of the PUnC core's debug port.
- Drives `mem_debug_addr` and `rf_debug_addr`, and samples `mem_debug_data`, `rf_debug_data` and `pc_debug_data`.
- On a start request it streams a tagged snapshot out over a valid/ready interface: PC, then R0–R7, then a caller-specified memory window.
- It sits beside the `PUnC` top-level in the test/SoC wrapper and feeds a UART or trace sink.

Parameters:
- `DATA_W`, 16, width of debug data words and of the memory address.
- `NUM_REGS`, 8, number of register-file entries dumped.
- `RF_ADDR_W`, 3, width of `rf_debug_addr`.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `start` input 1: one-cycle dump request; sampled only in IDLE.
- `mem_base` input DATA_W: first memory address to dump; captured on accepted start.
- `mem_len` input DATA_W: number of memory words to dump (0–65535); captured on accepted start.
- `busy` output 1: high from the cycle after an accepted start until the final word is accepted.
- `mem_debug_addr` output DATA_W: to core debug memory address.
- `rf_debug_addr` output RF_ADDR_W: to core debug register address.
- `mem_debug_data` input DATA_W: from core, combinational function of `mem_debug_addr`.
- `rf_debug_data` input DATA_W: from core, combinational function of `rf_debug_addr`.
- `pc_debug_data` input DATA_W: from core, current PC.
- `out_valid` output 1: stream word valid.
- `out_ready` input 1: sink ready.
- `out_data` output DATA_W: stream word.
- `out_tag` output 2: source of the word; 0 = PC, 1 = RF, 2 = MEM.
- `out_last` output 1: marks the final word of the dump.

Behaviour:
- Reset values (`rst` low, asynchronous):
  - State is IDLE.
  - `busy`, `out_valid` and `out_last` are 0.
  - `out_data`, `out_tag`, `mem_debug_addr` and `rf_debug_addr` are 0.
  - Internal counters are 0.
  - Reset mid-dump aborts with no further output; the sink sees a truncated dump without `out_last`.
- All outputs are registered. Debug addresses change only on clock edges.
- States: IDLE, SETUP, CAPTURE, SEND.
- IDLE:
  - `start` = 1 latches `mem_base` into `addr_q` and `mem_len` into `remain_q`.
  - Sets phase = PC and goes to SETUP; `busy` = 1 from the next cycle.
- SETUP:
  - Drives the address for the current phase: `rf_debug_addr` = `reg_idx` in RF, `mem_debug_addr` = `addr_q` in MEM, don't-care in PC.
  - Always goes to CAPTURE the next cycle, giving one full cycle of address settling.
- CAPTURE:
  - Registers the selected data into `out_data`: `pc_debug_data`, `rf_debug_data` or `mem_debug_data`.
  - Sets `out_tag` to the phase, sets `out_valid` = 1, sets `out_last` per the rule below, then goes to SEND.
- SEND:
  - `out_data`, `out_tag` and `out_last` stay stable while `out_valid` = 1 and `out_ready` = 0.
  - On `out_valid` && `out_ready`: `out_valid` drops next cycle, then the block advances:
    - PC → RF with `reg_idx` = 0.
    - RF with `reg_idx` < NUM_REGS-1 → `reg_idx`+1.
    - RF at the last register → MEM if `remain_q` != 0, else done.
    - MEM → `addr_q`+1 (wraps 16'hFFFF → 16'h0000), `remain_q`-1; done when `remain_q` reaches 0.
  - Next state is SETUP, or IDLE when done (`busy` clears the same edge).
- `out_last` rule:
  - 1 on R7 when `mem_len` = 0.
  - 1 on the MEM word when `remain_q` = 1.
  - 0 otherwise.
- Dump length is 1 + NUM_REGS + `mem_len` words.
- Throughput is at most one word per 3 cycles; each `out_ready` stall cycle adds one cycle.
- `start` while `busy` is ignored, with no queueing. `start` in the same cycle as the final handshake is also ignored; it is only accepted in IDLE.
- `mem_base` and `mem_len` changes after acceptance have no effect.
- Snapshot coherence against a running core is outside this block's scope. Each word reflects core state at its CAPTURE cycle.

Decomposition:
- Shared package `punc_debug_pkg` holds:
  - the state enum (IDLE/SETUP/CAPTURE/SEND);
  - the phase enum (PC/RF/MEM);
  - the tag constants `TAG_PC` = 2'd0, `TAG_RF` = 2'd1, `TAG_MEM` = 2'd2.
- One sub-module: `punc_debug_out_reg`, a single-entry valid/ready output holding register with load and hold-stable behaviour, reusable by later trace blocks.
- Sequencing and counters stay in the top module.

Test Plan:
- Core preloaded with PC = 16'h3000, Rn = 16'h1110+n, `start` with `mem_base` = 16'h3000, `mem_len` = 3, mem = {16'hAAAA, 16'hBBBB, 16'hCCCC}, `out_ready` tied 1 → 12 words with tags 0,1×8,2×3 and data 16'h3000, 16'h1110..16'h1117, AAAA, BBBB, CCCC; `out_last` only on CCCC; `busy` low after the last handshake; 36 cycles from the start edge.
- `mem_len` = 0 → 9 words, `out_last` on R7 (16'h1117), no `mem_debug_addr` change from 0.
- `mem_base` = 16'hFFFE, `mem_len` = 4 → memory addresses FFFE, FFFF, 0000, 0001 in order.
- `out_ready` toggled pseudo-randomly, `out_ready` = 0 held 5 cycles on the R3 word → `out_data`/`out_tag`/`out_last` stable during the stall; no word lost or duplicated versus the first test.
- `start` pulsed again mid-dump with a different `mem_len` → ignored, original length completes. `rst` low during the MEM phase → all outputs 0 asynchronously, IDLE. A subsequent `start` produces a full, correct dump.
